// File: rtl/apb_mem_bridge_if.sv
// Signal bundle between the APB controller, the apb_mem_bridge completer and the
// synchronous SRAM port. Names are given from the bridge's point of view.
interface apb_mem_bridge_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int PADDR_WIDTH = 32
);
    logic                   i_psel;
    logic                   i_penable;
    logic                   i_pwrite;
    logic [PADDR_WIDTH-1:0] i_paddr;
    logic [DATA_WIDTH-1:0]  i_pwdata;
    logic [DATA_WIDTH-1:0]  o_prdata;
    logic                   o_pready;
    logic                   o_pslverr;

    logic                   o_mem_en;
    logic                   o_mem_wr;
    logic [ADDR_WIDTH-1:0]  o_mem_addr;
    logic [DATA_WIDTH-1:0]  o_mem_data_w;
    logic [DATA_WIDTH-1:0]  i_mem_data_r;

    // Bridge side.
    modport slave (
        input  i_psel, i_penable, i_pwrite, i_paddr, i_pwdata, i_mem_data_r,
        output o_prdata, o_pready, o_pslverr,
        output o_mem_en, o_mem_wr, o_mem_addr, o_mem_data_w
    );

    // Controller side, which here also owns the memory read-data return.
    modport master (
        output i_psel, i_penable, i_pwrite, i_paddr, i_pwdata, i_mem_data_r,
        input  o_prdata, o_pready, o_pslverr,
        input  o_mem_en, o_mem_wr, o_mem_addr, o_mem_data_w
    );
endinterface

// File: rtl/apb_mem_bridge.sv
// APB3 completer driving a single-port synchronous SRAM: one memory access per
// transfer, optional registered wait states, PSLVERR for out-of-range addresses.
module apb_mem_bridge #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int PADDR_WIDTH = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    apb_mem_bridge_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        RDCAP = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam bit       HAS_WAIT  = (WAIT_STATES > 0);
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    state_t                state_reg, state_next;
    logic                  err_reg, err_next;
    logic [3:0]            cnt_reg, cnt_next;
    logic                  mem_wr_reg, mem_wr_next;
    logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_WIDTH-1:0] mem_data_w_reg, mem_data_w_next;
    logic [DATA_WIDTH-1:0] prdata_reg, prdata_next;
    logic                  addr_oor;

    // Any set bit above the memory word-address range is a slave error.
    generate
        if (PADDR_WIDTH > ADDR_WIDTH) begin : g_oor
            assign addr_oor = |bus.i_paddr[PADDR_WIDTH-1:ADDR_WIDTH];
        end else begin : g_no_oor
            assign addr_oor = 1'b0;
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= IDLE;
            err_reg        <= 1'b0;
            cnt_reg        <= '0;
            mem_wr_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_data_w_reg <= '0;
            prdata_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            err_reg        <= err_next;
            cnt_reg        <= cnt_next;
            mem_wr_reg     <= mem_wr_next;
            mem_addr_reg   <= mem_addr_next;
            mem_data_w_reg <= mem_data_w_next;
            prdata_reg     <= prdata_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        err_next        = err_reg;
        cnt_next        = cnt_reg;
        mem_wr_next     = mem_wr_reg;
        mem_addr_next   = mem_addr_reg;
        mem_data_w_next = mem_data_w_reg;
        prdata_next     = prdata_reg;

        case (state_reg)
            IDLE: begin
                if (bus.i_psel && !bus.i_penable) begin
                    mem_wr_next     = bus.i_pwrite;
                    mem_addr_next   = bus.i_paddr[ADDR_WIDTH-1:0];
                    mem_data_w_next = bus.i_pwdata;
                    if (addr_oor) begin
                        state_next = RESP;
                        err_next   = 1'b1;
                        if (!bus.i_pwrite) begin
                            prdata_next = '0;
                        end
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (!mem_wr_reg) begin
                    state_next = RDCAP;
                end else if (HAS_WAIT) begin
                    state_next = WAIT;
                    cnt_next   = WAIT_LOAD;
                end else begin
                    state_next = RESP;
                end
            end
            RDCAP: begin
                // Memory returns data the cycle after the enabled edge.
                prdata_next = bus.i_mem_data_r;
                if (HAS_WAIT) begin
                    state_next = WAIT;
                    cnt_next   = WAIT_LOAD;
                end else begin
                    state_next = RESP;
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
                err_next   = 1'b0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.o_pready     = (state_reg == RESP);
    assign bus.o_pslverr    = (state_reg == RESP) && err_reg;
    assign bus.o_mem_en     = (state_reg == ISSUE);
    assign bus.o_mem_wr     = mem_wr_reg;
    assign bus.o_mem_addr   = mem_addr_reg;
    assign bus.o_mem_data_w = mem_data_w_reg;
    assign bus.o_prdata     = prdata_reg;

endmodule
